sdram_cmd_decode: RTL

SDRAM_CMD_DECODE -- requirements
Module: sdram_cmd_decode

---
 rtl/sdram_cmd_decode_pkg.sv | 11 +
 rtl/sdram_cmd_decode.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/sdram_cmd_decode_pkg.sv
// Frame-protocol constants shared by the UART command decoder and the SDRAM write/read paths.
// Pure constants; no logic, no latency, no flow control.
package sdram_cmd_decode_pkg;

  localparam logic [7:0] HEAD_DEF        = 8'h55;
  localparam logic [7:0] CMD_WR_DEF      = 8'hAA;
  localparam logic [7:0] CMD_RD_DEF      = 8'hBB;
  localparam int         PAYLOAD_LEN_DEF = 4;
  localparam int         TIMEOUT_END_DEF = 52079;

endpackage

// File: rtl/sdram_cmd_decode.sv
// Decodes UART frames (HEAD, CMD, payload) into SDRAM write-FIFO strobes and read/write triggers.
// Latency: strobes/rd_trig/err 1 cycle after accept, wr_trig 2; no backpressure, one byte per pi_flag rise.
module sdram_cmd_decode
  import sdram_cmd_decode_pkg::*;
#(
  parameter logic [7:0] HEAD        = HEAD_DEF,
  parameter logic [7:0] CMD_WR      = CMD_WR_DEF,
  parameter logic [7:0] CMD_RD      = CMD_RD_DEF,
  parameter int         PAYLOAD_LEN = PAYLOAD_LEN_DEF,
  parameter int         TIMEOUT_END = TIMEOUT_END_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic       wfifo_wr_en,
  output logic [7:0] wfifo_data,
  output logic       wr_trig,
  output logic       rd_trig,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {
    S_HEAD = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2
  } state_e;

  localparam logic [3:0]  LAST_CNT = 4'(PAYLOAD_LEN - 1);
  localparam logic [15:0] IDLE_END = 16'(TIMEOUT_END);

  state_e      state_q, state_d;
  logic [3:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] idle_q, idle_d;
  logic        pi_flag_q, pi_flag_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  data_q, data_d;
  logic        wr_pend_q, wr_pend_d;
  logic        wr_trig_q, wr_trig_d;
  logic        rd_trig_q, rd_trig_d;
  logic        err_q, err_d;
  logic        accept;
  logic        timeout;

  always_comb begin
    pi_flag_d  = pi_flag;
    accept     = pi_flag & ~pi_flag_q;
    timeout    = (idle_q == IDLE_END);
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    idle_d     = 16'd0;
    wr_en_d    = 1'b0;
    data_d     = data_q;
    wr_pend_d  = 1'b0;
    wr_trig_d  = wr_pend_q;
    rd_trig_d  = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      S_HEAD: begin
        if (accept && pi_data == HEAD) state_d = S_CMD;
      end

      S_CMD: begin
        idle_d = idle_q + 16'd1;
        if (accept) begin
          idle_d = 16'd0;
          if (pi_data == CMD_WR) begin
            byte_cnt_d = 4'd0;
            state_d    = S_DATA;
          end else begin
            state_d = S_HEAD;
            if (pi_data == CMD_RD) rd_trig_d = 1'b1;
            else                   err_d     = 1'b1;
          end
        end else if (timeout) begin
          idle_d     = 16'd0;
          byte_cnt_d = 4'd0;
          err_d      = 1'b1;
          state_d    = S_HEAD;
        end
      end

      S_DATA: begin
        idle_d = idle_q + 16'd1;
        // Any byte here is payload, even HEAD/CMD values: no resync mid-frame.
        if (accept) begin
          idle_d     = 16'd0;
          wr_en_d    = 1'b1;
          data_d     = pi_data;
          byte_cnt_d = byte_cnt_q + 4'd1;
          if (byte_cnt_q == LAST_CNT) begin
            wr_pend_d  = 1'b1;
            byte_cnt_d = 4'd0;
            state_d    = S_HEAD;
          end
        end else if (timeout) begin
          idle_d     = 16'd0;
          byte_cnt_d = 4'd0;
          err_d      = 1'b1;
          state_d    = S_HEAD;
        end
      end

      default: state_d = S_HEAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_HEAD;
      byte_cnt_q <= 4'd0;
      idle_q     <= 16'd0;
      pi_flag_q  <= 1'b0;
      wr_en_q    <= 1'b0;
      data_q     <= 8'h00;
      wr_pend_q  <= 1'b0;
      wr_trig_q  <= 1'b0;
      rd_trig_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      idle_q     <= idle_d;
      pi_flag_q  <= pi_flag_d;
      wr_en_q    <= wr_en_d;
      data_q     <= data_d;
      wr_pend_q  <= wr_pend_d;
      wr_trig_q  <= wr_trig_d;
      rd_trig_q  <= rd_trig_d;
      err_q      <= err_d;
    end
  end

  assign wfifo_wr_en = wr_en_q;
  assign wfifo_data  = data_q;
  assign wr_trig     = wr_trig_q;
  assign rd_trig     = rd_trig_q;
  assign err         = err_q;
  assign busy        = (state_q != S_HEAD);

endmodule
